// File: rtl/ac97_frame_tx.sv
// AC97 output frame generator: codec-ready wait, register-init writes, then PCM on slots 3/4.
// r_pos is the position launched at the next edge, so the outputs carry bit r_pos for the following cycle.
module ac97_frame_tx #(
    parameter int unsigned INIT_WRITES = 4
) (
    input  logic        BIT_CLK,
    input  logic        reset,
    input  logic        codec_ready,
    input  logic [19:0] waveIn,
    input  logic [10:0] frameMax,
    output logic        SYNC,
    output logic        SDATA_OUT,
    output logic        frame,
    output logic [10:0] frameCount,
    output logic        sample_req,
    output logic        ready
);

    typedef enum logic [1:0] {
        WAIT_READY,
        INIT,
        RUN
    } state_t;

    localparam logic [7:0] IDX_LAST = 8'(INIT_WRITES - 1);

    state_t      r_state;
    logic [7:0]  r_pos;
    logic [7:0]  r_idx;
    logic [19:0] r_hold;
    logic        r_live;
    logic        r_sync;
    logic        r_sdata;
    logic        r_frame;
    logic [10:0] r_fcount;
    logic        r_req;
    logic        r_ready;

    state_t      w_state_nx;
    logic [7:0]  w_idx_nx;
    logic        w_boundary;
    logic        w_last_init;
    logic [6:0]  w_addr;
    logic [15:0] w_data;
    logic [7:0]  w_rel_a;
    logic [7:0]  w_rel_d;
    logic [7:0]  w_rel_s;
    logic [6:0]  w_addr_sh;
    logic [15:0] w_data_sh;
    logic [19:0] w_hold_sh;
    logic        w_bit;

    // r_live suppresses a frame-boundary decision on the first edge after reset
    assign w_boundary  = r_live && (r_pos == 8'd0);
    assign w_last_init = (r_state == INIT) && (r_idx == IDX_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        if (w_boundary) begin
            if (!codec_ready) begin
                w_state_nx = WAIT_READY;
                w_idx_nx   = '0;
            end else begin
                case (r_state)
                    WAIT_READY: begin
                        w_state_nx = INIT;
                        w_idx_nx   = '0;
                    end
                    INIT: begin
                        if (w_last_init) begin
                            w_state_nx = RUN;
                            w_idx_nx   = '0;
                        end else begin
                            w_idx_nx = r_idx + 8'd1;
                        end
                    end
                    default: w_state_nx = RUN;
                endcase
            end
        end
    end

    always_comb begin
        w_addr = '0;
        w_data = '0;
        case (w_idx_nx)
            8'd0: begin w_addr = 7'h02; w_data = 16'h0000; end
            8'd1: begin w_addr = 7'h04; w_data = 16'h0000; end
            8'd2: begin w_addr = 7'h18; w_data = 16'h0808; end
            8'd3: begin w_addr = 7'h2C; w_data = 16'hBB80; end
            default: begin w_addr = '0; w_data = '0; end
        endcase
    end

    assign w_rel_a   = r_pos - 8'd17;
    assign w_rel_d   = r_pos - 8'd36;
    assign w_rel_s   = (r_pos < 8'd76) ? (r_pos - 8'd56) : (r_pos - 8'd76);
    assign w_addr_sh = w_addr << w_rel_a;
    assign w_data_sh = w_data << w_rel_d;
    assign w_hold_sh = r_hold << w_rel_s;

    always_comb begin
        w_bit = 1'b0;
        if (r_pos == 8'd0)
            w_bit = (w_state_nx != WAIT_READY);
        else if (r_pos <= 8'd2)
            w_bit = (w_state_nx == INIT);
        else if (r_pos <= 8'd4)
            w_bit = (w_state_nx == RUN);
        else if (r_pos >= 8'd17 && r_pos <= 8'd23)
            w_bit = (w_state_nx == INIT) && w_addr_sh[6];
        else if (r_pos >= 8'd36 && r_pos <= 8'd51)
            w_bit = (w_state_nx == INIT) && w_data_sh[15];
        else if (r_pos >= 8'd56 && r_pos <= 8'd95)
            w_bit = (w_state_nx == RUN) && w_hold_sh[19];
    end

    always_ff @(posedge BIT_CLK or posedge reset) begin
        if (reset) begin
            r_state  <= WAIT_READY;
            r_pos    <= '0;
            r_idx    <= '0;
            r_hold   <= '0;
            r_live   <= 1'b0;
            r_sync   <= 1'b0;
            r_sdata  <= 1'b0;
            r_frame  <= 1'b0;
            r_fcount <= '0;
            r_req    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_pos   <= r_pos + 8'd1;
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_sync  <= (r_pos < 8'd16);
            r_sdata <= w_bit;
            r_ready <= (w_state_nx == RUN);
            r_req   <= (r_pos == 8'd250) && ((r_state == RUN) || w_last_init);
            if (w_boundary)
                r_hold <= waveIn;
            if ((r_pos == 8'd0) && (w_state_nx == RUN)) begin
                r_frame <= 1'b1;
                if ((r_state != RUN) || (frameMax <= 11'd1) || (r_fcount >= frameMax - 11'd1))
                    r_fcount <= '0;
                else
                    r_fcount <= r_fcount + 11'd1;
            end else begin
                r_frame <= 1'b0;
            end
        end
    end

    assign SYNC       = r_sync;
    assign SDATA_OUT  = r_sdata;
    assign frame      = r_frame;
    assign frameCount = r_fcount;
    assign sample_req = r_req;
    assign ready      = r_ready;

endmodule
